// File: rtl/mask_memory_arbiter.sv
// Mask RAM arbiter: shares one single-port RAM between the CPU and the MAU.
// The `alive` input picks the high-priority requester. A wait counter force-grants
// the other requester after MAX_WAIT denied cycles. A clear sequencer writes
// CLEAR_VALUE to every usable word. Grants and RAM port drives are combinational,
// so a request is presented to the RAM in the same cycle it is granted.
module mask_memory_arbiter #(
  parameter int                    DATA_WIDTH  = 128,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    MAX_WAIT    = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alive,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_data_write,
  input  logic                  cpu_wren,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  mau_req,
  input  logic [ADDR_WIDTH-1:0] mau_address,
  input  logic [DATA_WIDTH-1:0] mau_data_write,
  input  logic                  mau_wren,
  output logic                  mau_gnt,
  output logic                  mau_rvalid,
  output logic [DATA_WIDTH-1:0] mau_rdata,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  ram_clk_en,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_write,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_data_read
);

  localparam logic [ADDR_WIDTH-1:0] RSV_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] LAST_CLR = RSV_ADDR - ADDR_WIDTH'(1);
  localparam int                    CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]         WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic {ST_SERVE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [CW-1:0]         r_wait;
  logic [CW-1:0]         w_wait_eff;
  logic                  r_alive_q;
  logic                  w_alive_chg;
  logic                  w_hi_req;
  logic                  w_lo_req;
  logic                  w_grant_hi;
  logic                  w_grant_lo;
  logic                  r_cpu_rvalid;
  logic                  r_mau_rvalid;
  logic                  r_cpu_rsv;
  logic                  r_mau_rsv;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_mau_rdata;
  logic                  r_clear_done;

  // Arbitration: role selection from alive, starvation override, one grant per cycle.
  always_comb begin
    w_alive_chg = alive ^ r_alive_q;
    // A role swap restarts the fairness window for the new low-priority side.
    w_wait_eff  = w_alive_chg ? '0 : r_wait;
    w_hi_req    = alive ? cpu_req : mau_req;
    w_lo_req    = alive ? mau_req : cpu_req;
    w_grant_hi  = 1'b0;
    w_grant_lo  = 1'b0;
    if (!reset && (r_state == ST_SERVE)) begin
      if (w_lo_req && (w_wait_eff == WAIT_MAX)) begin
        w_grant_lo = 1'b1;
      end else if (w_hi_req) begin
        w_grant_hi = 1'b1;
      end else if (w_lo_req) begin
        w_grant_lo = 1'b1;
      end else begin
        w_grant_lo = 1'b0;
      end
    end else begin
      w_grant_hi = 1'b0;
    end
    cpu_gnt = alive ? w_grant_hi : w_grant_lo;
    mau_gnt = alive ? w_grant_lo : w_grant_hi;
  end

  // RAM port drive: the clear sequencer owns the port in CLEAR, otherwise the granted requester does.
  always_comb begin
    ram_clk_en     = 1'b0;
    ram_wren       = 1'b0;
    ram_address    = '0;
    ram_data_write = '0;
    if (reset) begin
      ram_clk_en = 1'b0;
    end else if (r_state == ST_CLEAR) begin
      ram_clk_en     = 1'b1;
      ram_wren       = 1'b1;
      ram_address    = r_clr_addr;
      ram_data_write = CLEAR_VALUE;
    end else if (cpu_gnt) begin
      ram_clk_en     = 1'b1;
      ram_address    = cpu_address;
      ram_data_write = cpu_data_write;
      // Writes to the reserved word are accepted but never reach the RAM.
      ram_wren       = cpu_wren && (cpu_address != RSV_ADDR);
    end else if (mau_gnt) begin
      ram_clk_en     = 1'b1;
      ram_address    = mau_address;
      ram_data_write = mau_data_write;
      ram_wren       = mau_wren && (mau_address != RSV_ADDR);
    end else begin
      ram_clk_en = 1'b0;
    end
  end

  // Read return path and status outputs; rdata holds its last value between reads.
  always_comb begin
    cpu_rvalid = r_cpu_rvalid && !reset;
    mau_rvalid = r_mau_rvalid && !reset;
    cpu_rdata  = r_cpu_rdata;
    mau_rdata  = r_mau_rdata;
    if (cpu_rvalid) begin
      cpu_rdata = r_cpu_rsv ? {DATA_WIDTH{1'b1}} : ram_data_read;
    end else begin
      cpu_rdata = r_cpu_rdata;
    end
    if (mau_rvalid) begin
      mau_rdata = r_mau_rsv ? {DATA_WIDTH{1'b1}} : ram_data_read;
    end else begin
      mau_rdata = r_mau_rdata;
    end
    clear_busy = (r_state == ST_CLEAR) && !reset;
    clear_done = r_clear_done && !reset;
  end

  // Next-state logic for the SERVE/CLEAR sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_SERVE: begin
        if (clear_start) begin
          w_next_state = ST_CLEAR;
        end else begin
          w_next_state = ST_SERVE;
        end
      end
      ST_CLEAR: begin
        if (r_clr_addr == LAST_CLR) begin
          w_next_state = ST_SERVE;
        end else begin
          w_next_state = ST_CLEAR;
        end
      end
      default: w_next_state = ST_SERVE;
    endcase
  end

  // State, clear address, wait counter and read-return registers.
  always_ff @(posedge clk) begin
    r_alive_q <= alive;
    if (reset) begin
      r_state      <= ST_SERVE;
      r_clr_addr   <= '0;
      r_wait       <= '0;
      r_cpu_rvalid <= 1'b0;
      r_mau_rvalid <= 1'b0;
      r_cpu_rsv    <= 1'b0;
      r_mau_rsv    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_mau_rdata  <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_clr_addr   <= (r_state == ST_CLEAR) ? (r_clr_addr + ADDR_WIDTH'(1)) : '0;
      r_clear_done <= (r_state == ST_CLEAR) && (r_clr_addr == LAST_CLR);
      r_cpu_rvalid <= cpu_gnt && !cpu_wren;
      r_mau_rvalid <= mau_gnt && !mau_wren;
      r_cpu_rsv    <= cpu_address == RSV_ADDR;
      r_mau_rsv    <= mau_address == RSV_ADDR;
      if (cpu_rvalid) r_cpu_rdata <= cpu_rdata;
      if (mau_rvalid) r_mau_rdata <= mau_rdata;
      if (r_state == ST_CLEAR) begin
        r_wait <= r_wait;
      end else if (w_alive_chg || !w_lo_req || w_grant_lo) begin
        r_wait <= '0;
      end else if (r_wait != WAIT_MAX) begin
        r_wait <= r_wait + CW'(1);
      end else begin
        r_wait <= r_wait;
      end
    end
  end

endmodule

// File: tb/tb_mask_memory_arbiter.sv
// Directed testbench for mask_memory_arbiter with a behavioural 256x128 RAM model.
module tb_mask_memory_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         alive;
  logic         cpu_req, cpu_wren, cpu_gnt, cpu_rvalid;
  logic [7:0]   cpu_address;
  logic [127:0] cpu_data_write, cpu_rdata;
  logic         mau_req, mau_wren, mau_gnt, mau_rvalid;
  logic [7:0]   mau_address;
  logic [127:0] mau_data_write, mau_rdata;
  logic         clear_start, clear_busy, clear_done;
  logic         ram_clk_en, ram_wren;
  logic [7:0]   ram_address;
  logic [127:0] ram_data_write, ram_data_read;

  logic [127:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] PAT_AA = {16{8'hAA}};
  localparam logic [127:0] PAT_55 = {16{8'h55}};
  localparam logic [127:0] PAT_AB = {16{8'hAB}};
  localparam logic [127:0] PAT_CD = {16{8'hCD}};
  localparam logic [127:0] ONES   = {128{1'b1}};

  mask_memory_arbiter #(.DATA_WIDTH(128), .ADDR_WIDTH(8), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .alive(alive),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data_write(cpu_data_write),
    .cpu_wren(cpu_wren), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mau_req(mau_req), .mau_address(mau_address), .mau_data_write(mau_data_write),
    .mau_wren(mau_wren), .mau_gnt(mau_gnt), .mau_rvalid(mau_rvalid), .mau_rdata(mau_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_clk_en(ram_clk_en), .ram_address(ram_address), .ram_data_write(ram_data_write),
    .ram_wren(ram_wren), .ram_data_read(ram_data_read)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Single-port synchronous RAM model: q is valid one cycle after the address.
  always @(posedge clk) begin
    if (ram_clk_en) begin
      if (ram_wren) mem[ram_address] <= ram_data_write;
      ram_data_read <= mem[ram_address];
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cpu_gnt(input string tag);
    int k = 0;
    @(negedge clk);
    while (!cpu_gnt && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 128'(cpu_gnt), 128'(1'b1));
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [127:0] d, input logic exp_wren);
    cpu_req = 1'b1; cpu_wren = 1'b1; cpu_address = a; cpu_data_write = d;
    wait_cpu_gnt("wr_gnt");
    chk("wr_clk_en", 128'(ram_clk_en), 128'(1'b1));
    chk("wr_wren", 128'(ram_wren), 128'(exp_wren));
    cyc();
    cpu_req = 1'b0; cpu_wren = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [127:0] d);
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_address = a;
    wait_cpu_gnt("rd_gnt");
    cyc();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", 128'(cpu_rvalid), 128'(1'b1));
    d = cpu_rdata;
    cyc();
  endtask

  initial begin
    logic [127:0] rd;
    int busy, addr_err, gnt_err, done_cnt;
    bit exp_c [6];
    bit exp_m [6];
    exp_c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; alive = 1'b1; clear_start = 1'b0;
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_address = 8'h00; cpu_data_write = '0;
    mau_req = 1'b1; mau_wren = 1'b0; mau_address = 8'h00; mau_data_write = '0;
    #1;

    // Reset with both requests pending: nothing granted, RAM idle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt", 128'({cpu_gnt, mau_gnt}), 128'(2'b00));
      chk("rst_rvalid", 128'({cpu_rvalid, mau_rvalid}), 128'(2'b00));
      chk("rst_ram", 128'({ram_clk_en, ram_wren}), 128'(2'b00));
      chk("rst_busy", 128'({clear_busy, clear_done}), 128'(2'b00));
      cyc();
    end
    chk("rst_rdata", cpu_rdata | mau_rdata, 128'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", 128'({cpu_gnt, mau_gnt}), 128'(2'b10));
    cyc();
    cpu_req = 1'b0; mau_req = 1'b0;
    cyc();

    cpu_wr(8'h10, PAT_AA, 1'b1);
    cpu_wr(8'h20, PAT_55, 1'b1);

    // Priority with alive=1: CPU first, MAU one cycle later.
    cpu_req = 1'b1; cpu_address = 8'h10; mau_req = 1'b1; mau_address = 8'h20;
    @(negedge clk);
    chk("p1_n_gnt", 128'({cpu_gnt, mau_gnt}), 128'(2'b10));
    cyc(); cpu_req = 1'b0;
    @(negedge clk);
    chk("p1_n1_gnt", 128'({cpu_gnt, mau_gnt}), 128'(2'b01));
    chk("p1_cpu_rvalid", 128'(cpu_rvalid), 128'(1'b1));
    chk("p1_cpu_rdata", cpu_rdata, PAT_AA);
    cyc(); mau_req = 1'b0;
    @(negedge clk);
    chk("p1_mau_rvalid", 128'({cpu_rvalid, mau_rvalid}), 128'(2'b01));
    chk("p1_mau_rdata", mau_rdata, PAT_55);
    chk("p1_cpu_hold", cpu_rdata, PAT_AA);
    cyc();

    // Priority with alive=0: MAU first.
    alive = 1'b0;
    cpu_req = 1'b1; cpu_address = 8'h10; mau_req = 1'b1; mau_address = 8'h20;
    @(negedge clk);
    chk("p0_n_gnt", 128'({cpu_gnt, mau_gnt}), 128'(2'b01));
    cyc(); mau_req = 1'b0;
    @(negedge clk);
    chk("p0_n1_gnt", 128'({cpu_gnt, mau_gnt}), 128'(2'b10));
    chk("p0_mau_rdata", 128'({mau_rvalid, mau_rdata[7:0]}), 128'({1'b1, 8'h55}));
    cyc(); cpu_req = 1'b0;
    @(negedge clk);
    chk("p0_cpu_rdata", 128'({cpu_rvalid, cpu_rdata[7:0]}), 128'({1'b1, 8'hAA}));
    cyc();

    // Starvation: MAX_WAIT=4, MAU force-granted at cycle 4.
    alive = 1'b1;
    cyc();
    cpu_req = 1'b1; cpu_address = 8'h10; mau_req = 1'b1; mau_address = 8'h20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("starve_cpu_c%0d", c), 128'(cpu_gnt), 128'(exp_c[c]));
      chk($sformatf("starve_mau_c%0d", c), 128'(mau_gnt), 128'(exp_m[c]));
      cyc();
    end
    cpu_req = 1'b0; mau_req = 1'b0;
    cyc(); cyc();

    // Reserved address: write dropped, read returns all ones.
    cpu_wr(8'hFF, 128'h1234, 1'b0);
    cpu_rd(8'hFF, rd);
    chk("rsv_rdata", rd, ONES);

    // Full clear with a CPU read held pending throughout.
    cpu_wr(8'h05, PAT_AB, 1'b1);
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_address = 8'h05;
    busy = 0; addr_err = 0; gnt_err = 0; done_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (clear_busy) begin
        busy++;
        if (ram_address !== 8'(busy - 1) || !ram_wren || !ram_clk_en) addr_err++;
        if (cpu_gnt || mau_gnt) gnt_err++;
      end
      if (clear_done) begin
        done_cnt++;
        break;
      end
      cyc();
      clear_start = (busy == 50);
    end
    chk("clr_busy_cycles", 128'(busy), 128'(255));
    chk("clr_addr_seq", 128'(addr_err), 128'(0));
    chk("clr_no_gnt", 128'(gnt_err), 128'(0));
    chk("clr_done_pulse", 128'(done_cnt), 128'(1));
    chk("clr_done_busy", 128'(clear_busy), 128'(1'b0));
    chk("clr_done_cpu_gnt", 128'(cpu_gnt), 128'(1'b1));
    cyc();
    cpu_req = 1'b0; clear_start = 1'b0;
    @(negedge clk);
    chk("clr_rd_rvalid", 128'(cpu_rvalid), 128'(1'b1));
    chk("clr_rd_rdata", cpu_rdata, 128'(0));
    chk("clr_done_once", 128'(clear_done), 128'(1'b0));
    cyc();

    // Reset in the middle of a clear.
    cpu_wr(8'h05, PAT_AB, 1'b1);
    cpu_wr(8'hC8, PAT_CD, 1'b1);
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    busy = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (clear_busy) busy++;
      if (busy == 100) break;
      cyc();
    end
    chk("mrst_reached", 128'(busy), 128'(100));
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 128'(clear_busy), 128'(1'b0));
    chk("mrst_wren", 128'(ram_wren), 128'(1'b0));
    done_cnt = 0; busy = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (clear_done) done_cnt++;
      if (clear_busy) busy++;
    end
    chk("mrst_no_done", 128'(done_cnt), 128'(0));
    chk("mrst_no_busy", 128'(busy), 128'(0));
    cyc();
    cpu_rd(8'h05, rd);
    chk("mrst_rd_05", rd, 128'(0));
    cpu_rd(8'hC8, rd);
    chk("mrst_rd_c8", rd, PAT_CD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
